gb_apu_pulse_regs: RTL and testbench

GB_APU_PULSE_REGS -- requirements
Module: gb_apu_pulse_regs

---
 rtl/gb_apu_pkg.sv | 51 +++++
 rtl/gb_apu_pulse_regs_if.sv | 22 ++
 rtl/gb_apu_trigger_pulse.sv | 81 ++++++++
 rtl/gb_apu_pulse_regs.sv | 139 +++++++++++++
 tb/tb_gb_apu_pulse_regs.sv | 301 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/gb_apu_pkg.sv
`default_nettype none
// ============================================================================
//  Module : gb_apu_pkg
//  Shared definitions for the Game Boy APU channel register blocks:
//  register offsets, read-back masks, trigger pulse length and the trigger
//  FSM state encoding.
//  Revision: 1.0 - initial release
// ============================================================================
package gb_apu_pkg;

  // Register offsets within one channel's window (NRx0..NRx4).
  localparam logic [2:0] ADDR_NRX0 = 3'd0;
  localparam logic [2:0] ADDR_NRX1 = 3'd1;
  localparam logic [2:0] ADDR_NRX2 = 3'd2;
  localparam logic [2:0] ADDR_NRX3 = 3'd3;
  localparam logic [2:0] ADDR_NRX4 = 3'd4;

  // Bits that always read as 1 (write-only or unimplemented bits).
  localparam logic [7:0] MASK_NRX0     = 8'h80;
  localparam logic [7:0] MASK_NRX1     = 8'h3F;
  localparam logic [7:0] MASK_NRX2     = 8'h00;
  localparam logic [7:0] MASK_NRX3     = 8'hFF;
  localparam logic [7:0] MASK_NRX4     = 8'hBF;
  localparam logic [7:0] MASK_UNMAPPED = 8'hFF;

  // Length of the start pulse presented to the channel, in clk cycles.
  localparam int START_PULSE_CYCLES = 4;
  localparam int START_CNT_W        = $clog2(START_PULSE_CYCLES);

  typedef enum logic [1:0] {
    TRIG_IDLE  = 2'd0,
    TRIG_PULSE = 2'd1,
    TRIG_GAP   = 2'd2
  } trig_state_e;

  function automatic logic [7:0] read_mask(input logic [2:0] addr);
    logic [7:0] m;
    m = MASK_UNMAPPED;
    case (addr)
      ADDR_NRX0: m = MASK_NRX0;
      ADDR_NRX1: m = MASK_NRX1;
      ADDR_NRX2: m = MASK_NRX2;
      ADDR_NRX3: m = MASK_NRX3;
      ADDR_NRX4: m = MASK_NRX4;
      default:   m = MASK_UNMAPPED;
    endcase
    return m;
  endfunction

endpackage
`default_nettype wire

// File: rtl/gb_apu_pulse_regs_if.sv
`default_nettype none
// ============================================================================
//  Interface : gb_apu_pulse_regs_if
//  CPU-side register bus of one APU channel register block.
//    addr  - register offset (0..4 mapped, 5..7 unmapped)
//    wr    - single-cycle write strobe
//    rd    - single-cycle read strobe
//    wdata - write data
//    rdata - registered read data (driven by the register block)
//  Revision: 1.0 - initial release
// ============================================================================
interface gb_apu_pulse_regs_if;
  logic [2:0] addr;
  logic       wr;
  logic       rd;
  logic [7:0] wdata;
  logic [7:0] rdata;

  modport master (output addr, output wr, output rd, output wdata, input rdata);
  modport slave  (input addr, input wr, input rd, input wdata, output rdata);
endinterface
`default_nettype wire

// File: rtl/gb_apu_trigger_pulse.sv
`default_nettype none
// ============================================================================
//  Module : gb_apu_trigger_pulse
//  Turns single-cycle trigger requests into a START_PULSE_CYCLES-long start
//  level. A request while the pulse is high inserts a one-cycle low gap and
//  restarts the pulse, so the channel always sees a fresh rising edge.
//  Ports:
//    clk   - clock
//    reset - synchronous active-high reset
//    req   - trigger request (single cycle)
//    kill  - forces IDLE (APU powered off)
//    start - trigger level to the channel
//  Revision: 1.0 - initial release
// ============================================================================
module gb_apu_trigger_pulse
  import gb_apu_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic req,
  input  logic kill,
  output logic start
);

  localparam logic [START_CNT_W-1:0] C_RELOAD = START_CNT_W'(START_PULSE_CYCLES - 1);

  trig_state_e            r_state;
  trig_state_e            w_state_nxt;
  logic [START_CNT_W-1:0] r_cnt;
  logic [START_CNT_W-1:0] w_cnt_nxt;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= TRIG_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    start       = 1'b0;
    case (r_state)
      TRIG_IDLE: begin
        if (req) begin
          w_state_nxt = TRIG_PULSE;
          w_cnt_nxt   = C_RELOAD;
        end
      end
      TRIG_PULSE: begin
        start = 1'b1;
        // A re-trigger wins over expiry: the gap guarantees a new edge.
        if (req) begin
          w_state_nxt = TRIG_GAP;
        end else if (r_cnt == '0) begin
          w_state_nxt = TRIG_IDLE;
        end else begin
          w_cnt_nxt = r_cnt - 1'b1;
        end
      end
      TRIG_GAP: begin
        // Requests arriving here are absorbed by the pulse about to start.
        w_state_nxt = TRIG_PULSE;
        w_cnt_nxt   = C_RELOAD;
      end
      default: begin
        w_state_nxt = TRIG_IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
    if (kill) begin
      w_state_nxt = TRIG_IDLE;
      w_cnt_nxt   = '0;
    end
  end

endmodule
`default_nettype wire

// File: rtl/gb_apu_pulse_regs.sv
`default_nettype none
// ============================================================================
//  Module : gb_apu_pulse_regs
//  Register block of a Game Boy APU pulse channel (NRx0..NRx4).
//  HAS_SWEEP=1 gives channel 1 (with sweep register), 0 gives channel 2.
//  Ports:
//    clk, reset        - clock and synchronous active-high reset
//    apu_power         - NR52 bit 7; while 0 registers are held cleared
//    bus               - CPU register bus (addr/wr/rd/wdata/rdata)
//    sweep_*, wave_duty, length, initial_volume, envelope_*, single,
//    frequency         - register fields to the channel
//    start             - trigger level (channel edge-detects it)
//    dac_enable        - NRx2[7:3] != 0
//  Revision: 1.0 - initial release
// ============================================================================
module gb_apu_pulse_regs
  import gb_apu_pkg::*;
#(
  parameter int HAS_SWEEP = 1
)(
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      apu_power,
  gb_apu_pulse_regs_if.slave        bus,
  output logic [2:0]                sweep_time,
  output logic                      sweep_decreasing,
  output logic [2:0]                num_sweep_shifts,
  output logic [1:0]                wave_duty,
  output logic [5:0]                length,
  output logic [3:0]                initial_volume,
  output logic                      envelope_increasing,
  output logic [2:0]                num_envelope_sweeps,
  output logic                      single,
  output logic [10:0]               frequency,
  output logic                      start,
  output logic                      dac_enable
);

  logic       w_wr_en;
  logic       w_trig_req;
  logic [7:0] w_nr0_byte;
  logic [7:0] w_reg_byte;
  logic [7:0] r_nr1;
  logic [7:0] r_nr2;
  logic [7:0] r_nr3;
  logic       r_single;
  logic [2:0] r_freq_hi;

  assign w_wr_en    = bus.wr & apu_power;
  assign w_trig_req = w_wr_en & (bus.addr == ADDR_NRX4) & bus.wdata[7];

  // Holding the registers cleared while powered off also discards writes.
  always_ff @(posedge clk) begin
    if (reset || !apu_power) begin
      r_nr1     <= '0;
      r_nr2     <= '0;
      r_nr3     <= '0;
      r_single  <= 1'b0;
      r_freq_hi <= '0;
    end else if (w_wr_en) begin
      case (bus.addr)
        ADDR_NRX1: r_nr1 <= bus.wdata;
        ADDR_NRX2: r_nr2 <= bus.wdata;
        ADDR_NRX3: r_nr3 <= bus.wdata;
        ADDR_NRX4: begin
          r_single  <= bus.wdata[6];
          r_freq_hi <= bus.wdata[2:0];
        end
        default: ;
      endcase
    end
  end

  generate
    if (HAS_SWEEP != 0) begin : g_sweep
      logic [6:0] r_nr0;

      always_ff @(posedge clk) begin
        if (reset || !apu_power) begin
          r_nr0 <= '0;
        end else if (w_wr_en && (bus.addr == ADDR_NRX0)) begin
          r_nr0 <= bus.wdata[6:0];
        end
      end

      assign w_nr0_byte       = {1'b0, r_nr0};
      assign sweep_time       = r_nr0[6:4];
      assign sweep_decreasing = r_nr0[3];
      assign num_sweep_shifts = r_nr0[2:0];
    end else begin : g_no_sweep
      // Channel 2 has no NRx0: the slot reads back as unmapped.
      assign w_nr0_byte       = MASK_UNMAPPED;
      assign sweep_time       = 3'd0;
      assign sweep_decreasing = 1'b0;
      assign num_sweep_shifts = 3'd0;
    end
  endgenerate

  assign wave_duty           = r_nr1[7:6];
  assign length              = r_nr1[5:0];
  assign initial_volume      = r_nr2[7:4];
  assign envelope_increasing = r_nr2[3];
  assign num_envelope_sweeps = r_nr2[2:0];
  assign frequency           = {r_freq_hi, r_nr3};
  assign single              = r_single;
  assign dac_enable          = |r_nr2[7:3];

  always_comb begin
    w_reg_byte = 8'h00;
    case (bus.addr)
      ADDR_NRX0: w_reg_byte = w_nr0_byte;
      ADDR_NRX1: w_reg_byte = r_nr1;
      ADDR_NRX2: w_reg_byte = r_nr2;
      ADDR_NRX3: w_reg_byte = r_nr3;
      ADDR_NRX4: w_reg_byte = {1'b0, r_single, 3'b000, r_freq_hi};
      default:   w_reg_byte = 8'h00;
    endcase
  end

  // Sampled from the current register contents, so a same-cycle write to
  // the same offset is not visible to this read.
  always_ff @(posedge clk) begin
    if (reset) begin
      bus.rdata <= 8'h00;
    end else if (bus.rd) begin
      bus.rdata <= w_reg_byte | read_mask(bus.addr);
    end
  end

  gb_apu_trigger_pulse u_trigger (
    .clk   (clk),
    .reset (reset),
    .req   (w_trig_req),
    .kill  (~apu_power),
    .start (start)
  );

endmodule
`default_nettype wire

// File: tb/tb_gb_apu_pulse_regs.sv
`default_nettype none
// ============================================================================
//  Module : tb_gb_apu_pulse_regs
//  Self-checking bench for gb_apu_pulse_regs (channel 1 and channel 2
//  variants): register table, trigger pulse sequences, power-off, reset.
//  Revision: 1.0 - initial release
// ============================================================================
module tb_gb_apu_pulse_regs;

  logic clk = 1'b0;
  logic reset;
  logic apu_power;

  always #5 clk = ~clk;

  gb_apu_pulse_regs_if bus1 ();
  gb_apu_pulse_regs_if bus2 ();

  logic [2:0]  d1_sweep_time, d2_sweep_time;
  logic        d1_sweep_dec, d2_sweep_dec;
  logic [2:0]  d1_shifts, d2_shifts;
  logic [1:0]  d1_duty, d2_duty;
  logic [5:0]  d1_length, d2_length;
  logic [3:0]  d1_vol, d2_vol;
  logic        d1_env_inc, d2_env_inc;
  logic [2:0]  d1_env_sw, d2_env_sw;
  logic        d1_single, d2_single;
  logic [10:0] d1_freq, d2_freq;
  logic        d1_start, d2_start;
  logic        d1_dac, d2_dac;

  gb_apu_pulse_regs #(.HAS_SWEEP(1)) dut1 (
    .clk                 (clk),
    .reset               (reset),
    .apu_power           (apu_power),
    .bus                 (bus1),
    .sweep_time          (d1_sweep_time),
    .sweep_decreasing    (d1_sweep_dec),
    .num_sweep_shifts    (d1_shifts),
    .wave_duty           (d1_duty),
    .length              (d1_length),
    .initial_volume      (d1_vol),
    .envelope_increasing (d1_env_inc),
    .num_envelope_sweeps (d1_env_sw),
    .single              (d1_single),
    .frequency           (d1_freq),
    .start               (d1_start),
    .dac_enable          (d1_dac)
  );

  gb_apu_pulse_regs #(.HAS_SWEEP(0)) dut2 (
    .clk                 (clk),
    .reset               (reset),
    .apu_power           (apu_power),
    .bus                 (bus2),
    .sweep_time          (d2_sweep_time),
    .sweep_decreasing    (d2_sweep_dec),
    .num_sweep_shifts    (d2_shifts),
    .wave_duty           (d2_duty),
    .length              (d2_length),
    .initial_volume      (d2_vol),
    .envelope_increasing (d2_env_inc),
    .num_envelope_sweeps (d2_env_sw),
    .single              (d2_single),
    .frequency           (d2_freq),
    .start               (d2_start),
    .dac_enable          (d2_dac)
  );

  int n_checks = 0;
  int n_pass   = 0;

  typedef struct {
    bit         wr;
    bit         rd;
    logic [2:0] addr;
    logic [7:0] wdata;
    logic [7:0] exp_rdata;
    logic [7:0] e0, e1, e2, e3, e4;
  } vec_t;

  vec_t vecs[19];

  function automatic vec_t mk(input bit wr, input bit rd, input logic [2:0] addr,
                              input logic [7:0] wdata, input logic [7:0] exp_rdata,
                              input logic [7:0] e0, input logic [7:0] e1,
                              input logic [7:0] e2, input logic [7:0] e3,
                              input logic [7:0] e4);
    vec_t v;
    v.wr = wr; v.rd = rd; v.addr = addr; v.wdata = wdata; v.exp_rdata = exp_rdata;
    v.e0 = e0; v.e1 = e1; v.e2 = e2; v.e3 = e3; v.e4 = e4;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic bus1_idle();
    bus1.wr = 1'b0; bus1.rd = 1'b0; bus1.addr = 3'd0; bus1.wdata = 8'h00;
  endtask

  // e4 holds the stored NRx4 bits: bit6 = single, bits2:0 = frequency[10:8].
  task automatic chk_fields(input string tag, input logic [7:0] e0, input logic [7:0] e1,
                            input logic [7:0] e2, input logic [7:0] e3, input logic [7:0] e4);
    chk({tag, ".sweep_time"}, 32'(d1_sweep_time), 32'(e0[6:4]));
    chk({tag, ".sweep_dec"},  32'(d1_sweep_dec),  32'(e0[3]));
    chk({tag, ".shifts"},     32'(d1_shifts),     32'(e0[2:0]));
    chk({tag, ".duty"},       32'(d1_duty),       32'(e1[7:6]));
    chk({tag, ".length"},     32'(d1_length),     32'(e1[5:0]));
    chk({tag, ".volume"},     32'(d1_vol),        32'(e2[7:4]));
    chk({tag, ".env_inc"},    32'(d1_env_inc),    32'(e2[3]));
    chk({tag, ".env_sweeps"}, 32'(d1_env_sw),     32'(e2[2:0]));
    chk({tag, ".single"},     32'(d1_single),     32'(e4[6]));
    chk({tag, ".frequency"},  32'(d1_freq),       32'({e4[2:0], e3}));
    chk({tag, ".dac"},        32'(d1_dac),        32'(|e2[7:3]));
  endtask

  task automatic trig_write(input logic [7:0] d);
    bus1.wr = 1'b1; bus1.addr = 3'd4; bus1.wdata = d;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1);
  end

  initial begin
    logic [7:0] pat_b;
    logic [6:0] pat_c;
    logic [5:0] pat_a;

    bus1_idle();
    bus2.wr = 1'b0; bus2.rd = 1'b0; bus2.addr = 3'd0; bus2.wdata = 8'h00;
    reset = 1'b1;
    apu_power = 1'b1;
    repeat (3) step();
    reset = 1'b0;

    // Reset state
    chk("reset.rdata1", 32'(bus1.rdata), 32'h00);
    chk("reset.rdata2", 32'(bus2.rdata), 32'h00);
    chk("reset.start",  32'(d1_start),   32'h0);
    chk_fields("reset", 8'h00, 8'h00, 8'h00, 8'h00, 8'h00);

    // Register table: expected values are cumulative register contents.
    vecs[0]  = mk(1, 0, 3'd1, 8'hC5, 8'h00, 8'h00, 8'hC5, 8'h00, 8'h00, 8'h00);
    vecs[1]  = mk(0, 1, 3'd1, 8'h00, 8'hFF, 8'h00, 8'hC5, 8'h00, 8'h00, 8'h00);
    vecs[2]  = mk(1, 0, 3'd0, 8'h2A, 8'hFF, 8'h2A, 8'hC5, 8'h00, 8'h00, 8'h00);
    vecs[3]  = mk(0, 1, 3'd0, 8'h00, 8'hAA, 8'h2A, 8'hC5, 8'h00, 8'h00, 8'h00);
    vecs[4]  = mk(1, 0, 3'd2, 8'h08, 8'hAA, 8'h2A, 8'hC5, 8'h08, 8'h00, 8'h00);
    vecs[5]  = mk(0, 1, 3'd2, 8'h00, 8'h08, 8'h2A, 8'hC5, 8'h08, 8'h00, 8'h00);
    vecs[6]  = mk(1, 0, 3'd2, 8'h07, 8'h08, 8'h2A, 8'hC5, 8'h07, 8'h00, 8'h00);
    vecs[7]  = mk(0, 1, 3'd2, 8'h00, 8'h07, 8'h2A, 8'hC5, 8'h07, 8'h00, 8'h00);
    vecs[8]  = mk(1, 0, 3'd3, 8'h34, 8'h07, 8'h2A, 8'hC5, 8'h07, 8'h34, 8'h00);
    vecs[9]  = mk(0, 1, 3'd3, 8'h00, 8'hFF, 8'h2A, 8'hC5, 8'h07, 8'h34, 8'h00);
    vecs[10] = mk(1, 0, 3'd4, 8'h07, 8'hFF, 8'h2A, 8'hC5, 8'h07, 8'h34, 8'h07);
    vecs[11] = mk(0, 1, 3'd4, 8'h00, 8'hBF, 8'h2A, 8'hC5, 8'h07, 8'h34, 8'h07);
    vecs[12] = mk(1, 0, 3'd4, 8'h47, 8'hBF, 8'h2A, 8'hC5, 8'h07, 8'h34, 8'h47);
    vecs[13] = mk(0, 1, 3'd4, 8'h00, 8'hFF, 8'h2A, 8'hC5, 8'h07, 8'h34, 8'h47);
    vecs[14] = mk(0, 1, 3'd5, 8'h00, 8'hFF, 8'h2A, 8'hC5, 8'h07, 8'h34, 8'h47);
    vecs[15] = mk(0, 1, 3'd7, 8'h00, 8'hFF, 8'h2A, 8'hC5, 8'h07, 8'h34, 8'h47);
    vecs[16] = mk(1, 1, 3'd2, 8'h91, 8'h07, 8'h2A, 8'hC5, 8'h91, 8'h34, 8'h47);
    vecs[17] = mk(0, 1, 3'd2, 8'h00, 8'h91, 8'h2A, 8'hC5, 8'h91, 8'h34, 8'h47);
    vecs[18] = mk(1, 0, 3'd6, 8'h55, 8'h91, 8'h2A, 8'hC5, 8'h91, 8'h34, 8'h47);

    for (int i = 0; i < 19; i++) begin
      bus1.wr = vecs[i].wr; bus1.rd = vecs[i].rd;
      bus1.addr = vecs[i].addr; bus1.wdata = vecs[i].wdata;
      step();
      bus1_idle();
      chk($sformatf("vec%0d.rdata", i), 32'(bus1.rdata), 32'(vecs[i].exp_rdata));
      chk($sformatf("vec%0d.start", i), 32'(d1_start), 32'h0);
      chk_fields($sformatf("vec%0d", i), vecs[i].e0, vecs[i].e1, vecs[i].e2,
                 vecs[i].e3, vecs[i].e4);
    end

    // Trigger with NRx4=0xC7: fields and start rise together, 4 cycles high.
    pat_a = 6'b001111;  // bit i = expected start at sample i
    trig_write(8'hC7);
    for (int i = 0; i < 6; i++) begin
      if (i > 0) bus1_idle();
      step();
      bus1_idle();
      chk($sformatf("trigA.start[%0d]", i), 32'(d1_start), 32'(pat_a[i]));
      if (i == 0) begin
        chk("trigA.freq",   32'(d1_freq),   32'h734);
        chk("trigA.single", 32'(d1_single), 32'h1);
      end
    end
    bus1.rd = 1'b1; bus1.addr = 3'd4;
    step();
    bus1_idle();
    chk("trigA.read_nr4", 32'(bus1.rdata), 32'hFF);

    // Re-trigger two cycles into the pulse: gap then a fresh 4-cycle pulse.
    pat_b = 8'b01111011;
    for (int i = 0; i < 8; i++) begin
      if (i == 0 || i == 2) trig_write(8'h80);
      step();
      bus1_idle();
      chk($sformatf("trigB.start[%0d]", i), 32'(d1_start), 32'(pat_b[i]));
    end
    chk("trigB.freq",   32'(d1_freq),   32'h034);
    chk("trigB.single", 32'(d1_single), 32'h0);

    // Requests on three consecutive cycles: the one landing in GAP is absorbed.
    pat_c = 7'b0111101;
    for (int i = 0; i < 7; i++) begin
      if (i < 3) trig_write(8'h80);
      step();
      bus1_idle();
      chk($sformatf("trigC.start[%0d]", i), 32'(d1_start), 32'(pat_c[i]));
    end

    // Power off mid-pulse.
    trig_write(8'h80);
    step();
    bus1_idle();
    chk("pwr.start_on", 32'(d1_start), 32'h1);
    apu_power = 1'b0;
    step();
    chk("pwr.start_off", 32'(d1_start), 32'h0);
    chk_fields("pwr.off", 8'h00, 8'h00, 8'h00, 8'h00, 8'h00);
    bus1.wr = 1'b1; bus1.addr = 3'd1; bus1.wdata = 8'h3F;
    step();
    bus1_idle();
    chk("pwr.wr_ignored_len",  32'(d1_length), 32'h0);
    chk("pwr.wr_ignored_duty", 32'(d1_duty),   32'h0);
    bus1.rd = 1'b1; bus1.addr = 3'd1;
    step();
    bus1_idle();
    chk("pwr.read_nr1", 32'(bus1.rdata), 32'h3F);
    bus1.rd = 1'b1; bus1.addr = 3'd0;
    step();
    bus1_idle();
    chk("pwr.read_nr0", 32'(bus1.rdata), 32'h80);
    trig_write(8'h80);
    step();
    bus1_idle();
    chk("pwr.trig_ignored", 32'(d1_start), 32'h0);
    apu_power = 1'b1;
    step();
    chk("pwr.on_length", 32'(d1_length), 32'h0);
    chk("pwr.on_start",  32'(d1_start),  32'h0);

    // Reset mid-pulse, with simultaneous write and read.
    bus1.wr = 1'b1; bus1.addr = 3'd1; bus1.wdata = 8'hC5;
    step();
    trig_write(8'h87);
    step();
    bus1_idle();
    chk("rst.start_on", 32'(d1_start), 32'h1);
    chk("rst.freq_on",  32'(d1_freq),  32'h700);
    reset = 1'b1;
    bus1.wr = 1'b1; bus1.rd = 1'b1; bus1.addr = 3'd1; bus1.wdata = 8'h11;
    step();
    bus1_idle();
    chk("rst.start", 32'(d1_start),   32'h0);
    chk("rst.rdata", 32'(bus1.rdata), 32'h00);
    chk_fields("rst", 8'h00, 8'h00, 8'h00, 8'h00, 8'h00);
    reset = 1'b0;
    step();
    chk("rst.start_after", 32'(d1_start), 32'h0);

    // Channel 2 variant: no sweep register.
    bus2.wr = 1'b1; bus2.addr = 3'd0; bus2.wdata = 8'h7F;
    step();
    bus2.wr = 1'b0;
    chk("ch2.sweep_time", 32'(d2_sweep_time), 32'h0);
    chk("ch2.sweep_dec",  32'(d2_sweep_dec),  32'h0);
    chk("ch2.shifts",     32'(d2_shifts),     32'h0);
    bus2.rd = 1'b1; bus2.addr = 3'd0;
    step();
    bus2.rd = 1'b0;
    chk("ch2.read_nr0", 32'(bus2.rdata), 32'hFF);
    bus2.rd = 1'b1; bus2.addr = 3'd6;
    step();
    bus2.rd = 1'b0;
    chk("ch2.read_off6", 32'(bus2.rdata), 32'hFF);
    bus2.wr = 1'b1; bus2.addr = 3'd1; bus2.wdata = 8'hC5;
    step();
    bus2.wr = 1'b0;
    chk("ch2.length", 32'(d2_length), 32'h05);
    chk("ch2.duty",   32'(d2_duty),   32'h3);
    chk("ch2.start",  32'(d2_start),  32'h0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
